// File: rtl/unified_mem_arb_pkg.sv
// Shared types for the unified instruction/data SRAM arbiter.
// Owner codes tag which requester, if any, owns the read data returning next cycle.
package ZionDataType;

   typedef logic [31:0] CpuType;

   typedef logic [1:0] ArbOwnerType;
   localparam ArbOwnerType IDLE = 2'd0;
   localparam ArbOwnerType IRD  = 2'd1;
   localparam ArbOwnerType DRD  = 2'd2;
   localparam ArbOwnerType DWR  = 2'd3;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating up-counter with synchronous clear; tracks consecutive denied fetch cycles.
module arb_starve_cnt #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cntQ;
   logic [WIDTH-1:0] cntD;

   always_comb begin
      cntD = cntQ;
      if (clr) begin
         cntD = '0;
      end else if (inc && (cntQ != '1)) begin
         cntD = cntQ + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cntQ <= '0;
      end else begin
         cntQ <= cntD;
      end
   end

   assign cnt = cntQ;

endmodule

// File: rtl/unified_mem_arb.sv
// Single-port SRAM arbiter between instruction fetch and data access.
// Data wins by default; fetch is promoted after STARVE_MAX consecutive denials.
module unified_mem_arb
   import ZionDataType::*;
#(
   parameter int unsigned CACHE_WIDTHE  = 5,
   parameter int unsigned CACHE_DEEPTHE = 12,
   parameter int unsigned STARVE_MAX    = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         IReq,
   input  logic [CACHE_DEEPTHE-1:0]     IAddr,
   output logic                         IGnt,
   output logic                         IRdValid,
   output logic [(2**CACHE_WIDTHE)-1:0] IRdData,
   input  logic                         DReq,
   input  logic                         DWrEn,
   input  logic [CACHE_DEEPTHE-1:0]     DAddr,
   input  CpuType                       DWrMask,
   input  CpuType                       DWrData,
   output logic                         DGnt,
   output logic                         DRdValid,
   output CpuType                       DRdData,
   output logic                         MemCen,
   output logic                         MemWrEn,
   output logic [CACHE_DEEPTHE-1:0]     MemAddr,
   output CpuType                       MemWrMask,
   output CpuType                       MemWrData,
   input  CpuType                       MemRdData,
   output logic                         FeStall
);

   localparam int unsigned IW = 2 ** CACHE_WIDTHE;
   localparam logic [1:0] StarveMaxC = 2'(STARVE_MAX);

   logic [1:0]               starveCnt;
   logic                     starveFull;
   logic                     anyGnt;
   logic [CACHE_DEEPTHE-1:0] selAddr;
   CpuType                   selMask;
   CpuType                   selData;
   logic [CACHE_DEEPTHE-1:0] memAddrQ;
   CpuType                   memWrMaskQ;
   CpuType                   memWrDataQ;
   ArbOwnerType              ownerQ;
   ArbOwnerType              ownerD;

   assign starveFull = (starveCnt == StarveMaxC);

   // Grants are gated by reset so nothing reaches the SRAM while rst_n is low.
   assign DGnt    = rst_n & DReq & ~(IReq & starveFull);
   assign IGnt    = rst_n & IReq & ~DGnt;
   assign anyGnt  = IGnt | DGnt;
   assign FeStall = IReq & ~IGnt;

   arb_starve_cnt #(
      .WIDTH (2)
   ) uStarve (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (IReq & ~IGnt),
      .clr   (~IReq | IGnt),
      .cnt   (starveCnt)
   );

   always_comb begin
      selAddr = IAddr;
      selMask = '0;
      selData = '0;
      if (DGnt) begin
         selAddr = DAddr;
         selMask = DWrMask;
         selData = DWrData;
      end
   end

   assign MemCen    = ~anyGnt;
   assign MemWrEn   = DGnt & DWrEn;
   assign MemAddr   = anyGnt ? selAddr : memAddrQ;
   assign MemWrMask = anyGnt ? selMask : memWrMaskQ;
   assign MemWrData = anyGnt ? selData : memWrDataQ;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         memAddrQ   <= '0;
         memWrMaskQ <= '0;
         memWrDataQ <= '0;
      end else if (anyGnt) begin
         memAddrQ   <= selAddr;
         memWrMaskQ <= selMask;
         memWrDataQ <= selData;
      end
   end

   always_comb begin
      ownerD = IDLE;
      if (IGnt) begin
         ownerD = IRD;
      end else if (DGnt) begin
         ownerD = DWrEn ? DWR : DRD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ownerQ <= IDLE;
      end else begin
         ownerQ <= ownerD;
      end
   end

   // Reset in the return cycle discards the in-flight read.
   assign IRdValid = rst_n & (ownerQ == IRD);
   assign DRdValid = rst_n & (ownerQ == DRD);
   assign IRdData  = IRdValid ? IW'(MemRdData) : '0;
   assign DRdData  = DRdValid ? MemRdData : '0;

endmodule

// File: tb/tb_unified_mem_arb.sv
// Directed bench for unified_mem_arb with a behavioural registered-read SRAM model.
module tb_unified_mem_arb;

   logic        clk;
   logic        rst_n;
   logic        IReq;
   logic [11:0] IAddr;
   logic        IGnt;
   logic        IRdValid;
   logic [31:0] IRdData;
   logic        DReq;
   logic        DWrEn;
   logic [11:0] DAddr;
   logic [31:0] DWrMask;
   logic [31:0] DWrData;
   logic        DGnt;
   logic        DRdValid;
   logic [31:0] DRdData;
   logic        MemCen;
   logic        MemWrEn;
   logic [11:0] MemAddr;
   logic [31:0] MemWrMask;
   logic [31:0] MemWrData;
   logic [31:0] MemRdData;
   logic        FeStall;

   logic [31:0] mem [0:4095];
   int          nAsserts;
   int          nFails;

   unified_mem_arb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .IReq      (IReq),
      .IAddr     (IAddr),
      .IGnt      (IGnt),
      .IRdValid  (IRdValid),
      .IRdData   (IRdData),
      .DReq      (DReq),
      .DWrEn     (DWrEn),
      .DAddr     (DAddr),
      .DWrMask   (DWrMask),
      .DWrData   (DWrData),
      .DGnt      (DGnt),
      .DRdValid  (DRdValid),
      .DRdData   (DRdData),
      .MemCen    (MemCen),
      .MemWrEn   (MemWrEn),
      .MemAddr   (MemAddr),
      .MemWrMask (MemWrMask),
      .MemWrData (MemWrData),
      .MemRdData (MemRdData),
      .FeStall   (FeStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: bit-masked write, registered read.
   always @(posedge clk) begin
      if (!MemCen) begin
         if (MemWrEn) begin
            mem[MemAddr] <= (mem[MemAddr] & ~MemWrMask) | (MemWrData & MemWrMask);
         end else begin
            MemRdData <= mem[MemAddr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   initial begin
      nAsserts  = 0;
      nFails    = 0;
      MemRdData = '0;
      for (int a = 0; a < 4096; a++) mem[a] = '0;
      mem[12'h010] = 32'h0000_0013;
      mem[12'h100] = 32'h1111_1111;
      mem[12'h020] = 32'h5555_7777;

      rst_n = 1'b0; IReq = 1'b1; IAddr = 12'h010;
      DReq = 1'b0; DWrEn = 1'b0; DAddr = '0; DWrMask = '0; DWrData = '0;
      repeat (2) @(posedge clk);

      // Reset state
      @(negedge clk); #1;
      chk("rst_IGnt", 32'(IGnt), 32'd0);
      chk("rst_DGnt", 32'(DGnt), 32'd0);
      chk("rst_MemCen", 32'(MemCen), 32'd1);
      chk("rst_MemWrEn", 32'(MemWrEn), 32'd0);
      chk("rst_FeStall", 32'(FeStall), 32'd1);
      chk("rst_IRdValid", 32'(IRdValid), 32'd0);
      chk("rst_DRdValid", 32'(DRdValid), 32'd0);

      // Fetch only
      @(negedge clk); rst_n = 1'b1; #1;
      chk("fe_IGnt", 32'(IGnt), 32'd1);
      chk("fe_MemCen", 32'(MemCen), 32'd0);
      chk("fe_MemAddr", 32'(MemAddr), 32'h010);
      chk("fe_MemWrEn", 32'(MemWrEn), 32'd0);
      chk("fe_FeStall", 32'(FeStall), 32'd0);
      @(negedge clk); IReq = 1'b0; #1;
      chk("fe_IRdValid", 32'(IRdValid), 32'd1);
      chk("fe_IRdData", IRdData, 32'h0000_0013);
      chk("fe_DRdValid", 32'(DRdValid), 32'd0);
      chk("idle_MemCen", 32'(MemCen), 32'd1);
      chk("idle_MemAddrHeld", 32'(MemAddr), 32'h010);

      // Simultaneous: data wins
      @(negedge clk); IReq = 1'b1; DReq = 1'b1; DAddr = 12'h100; #1;
      chk("sim_DGnt", 32'(DGnt), 32'd1);
      chk("sim_IGnt", 32'(IGnt), 32'd0);
      chk("sim_FeStall", 32'(FeStall), 32'd1);
      chk("sim_MemAddr", 32'(MemAddr), 32'h100);
      @(negedge clk); DReq = 1'b0; #1;
      chk("sim_DRdValid", 32'(DRdValid), 32'd1);
      chk("sim_DRdData", DRdData, 32'h1111_1111);
      chk("sim_IGnt2", 32'(IGnt), 32'd1);
      @(negedge clk); IReq = 1'b0; #1;
      chk("sim_IRdValid", 32'(IRdValid), 32'd1);
      chk("sim_IRdData", IRdData, 32'h0000_0013);

      // Starvation: three denials then fetch promoted
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); IReq = 1'b1; DReq = 1'b1; DAddr = 12'h100; #1;
         chk($sformatf("stv_cnt%0d", c), 32'(dut.starveCnt), 32'(c));
         chk($sformatf("stv_DGnt%0d", c), 32'(DGnt), (c < 3) ? 32'd1 : 32'd0);
         chk($sformatf("stv_IGnt%0d", c), 32'(IGnt), (c < 3) ? 32'd0 : 32'd1);
      end
      @(negedge clk); IReq = 1'b0; DReq = 1'b0; #1;
      chk("stv_cntClr", 32'(dut.starveCnt), 32'd0);
      chk("stv_IRdValid", 32'(IRdValid), 32'd1);

      // Store, then load back
      @(negedge clk);
      DReq = 1'b1; DWrEn = 1'b1; DAddr = 12'h020;
      DWrMask = 32'h0000_FFFF; DWrData = 32'hABCD_1234; #1;
      chk("st_DGnt", 32'(DGnt), 32'd1);
      chk("st_MemWrEn", 32'(MemWrEn), 32'd1);
      chk("st_MemWrMask", MemWrMask, 32'h0000_FFFF);
      chk("st_MemWrData", MemWrData, 32'hABCD_1234);
      chk("st_MemAddr", 32'(MemAddr), 32'h020);
      @(negedge clk); DReq = 1'b0; DWrEn = 1'b0; #1;
      chk("st_noDRdValid", 32'(DRdValid), 32'd0);
      chk("st_noIRdValid", 32'(IRdValid), 32'd0);
      chk("st_idleWrEn", 32'(MemWrEn), 32'd0);
      chk("st_maskHeld", MemWrMask, 32'h0000_FFFF);
      @(negedge clk); DReq = 1'b1; #1;
      chk("ld_DGnt", 32'(DGnt), 32'd1);
      chk("ld_MemWrMask", 32'(MemWrEn), 32'd0);
      @(negedge clk); DReq = 1'b0; #1;
      chk("ld_DRdValid", 32'(DRdValid), 32'd1);
      chk("ld_DRdData", DRdData, 32'h5555_1234);

      // Reset in the read-return cycle
      @(negedge clk); DReq = 1'b1; DAddr = 12'h100; #1;
      chk("rr_DGnt", 32'(DGnt), 32'd1);
      @(negedge clk); DReq = 1'b0; rst_n = 1'b0; #1;
      chk("rr_DRdValid", 32'(DRdValid), 32'd0);
      chk("rr_MemCen", 32'(MemCen), 32'd1);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("rr_owner", 32'(dut.ownerQ), 32'd0);
      chk("rr_DRdValid2", 32'(DRdValid), 32'd0);

      // Back-to-back alternating fetch/data loads
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         IReq = (i < 8) && (i % 2 == 0);
         DReq = (i < 8) && (i % 2 == 1);
         IAddr = 12'h010; DAddr = 12'h100; DWrEn = 1'b0;
         #1;
         if (i < 8) begin
            chk($sformatf("b2b_gnt%0d", i), 32'({IGnt, DGnt}),
                (i % 2 == 0) ? 32'b10 : 32'b01);
         end
         if (i > 0) begin
            if ((i - 1) % 2 == 0) begin
               chk($sformatf("b2b_val%0d", i), 32'({IRdValid, DRdValid}), 32'b10);
               chk($sformatf("b2b_idat%0d", i), IRdData, 32'h0000_0013);
            end else begin
               chk($sformatf("b2b_val%0d", i), 32'({IRdValid, DRdValid}), 32'b01);
               chk($sformatf("b2b_ddat%0d", i), DRdData, 32'h1111_1111);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/unified_mem_arb.md
UNIFIED_MEM_ARB -- requirements
Module: unified_mem_arb

Interface
REQ-001 SHALL have parameter CACHE_WIDTHE, default 5, meaning log2 of the data word width (32 bits).
REQ-002 SHALL have parameter CACHE_DEEPTHE, default 12, meaning word-address width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive denied fetch cycles before fetch is promoted.
REQ-004 SHALL use one clock; reset is synchronous and active-low. Ports are listed below.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 IReq  in  1  instruction-fetch read request.
REQ-008 IAddr  in  CACHE_DEEPTHE  fetch word address.
REQ-009 IGnt  out  1  fetch request accepted this cycle.
REQ-010 IRdValid  out  1  IRdData valid, one cycle after IGnt.
REQ-011 IRdData  out  2**CACHE_WIDTHE  fetched instruction word.
REQ-012 DReq  in  1  data access request.
REQ-013 DWrEn  in  1  1 = store, 0 = load.
REQ-014 DAddr, DWrMask, DWrData  in  CACHE_DEEPTHE, 32, 32  data address, bit write mask, store data.
REQ-015 DGnt  out  1  data request accepted this cycle.
REQ-016 DRdValid  out  1  DRdData valid, one cycle after a load grant.
REQ-017 DRdData  out  32  load data.
REQ-018 MemCen  out  1  SRAM chip enable, active-low.
REQ-019 MemWrEn, MemAddr, MemWrMask, MemWrData  out  1, CACHE_DEEPTHE, 32, 32  SRAM write enable, address, mask and data.
REQ-020 MemRdData  in  32  SRAM read data, registered, valid one cycle after access.
REQ-021 FeStall  out  1  fetch stall to front end, equal to IReq & ~IGnt.

Function
REQ-022 The arbiter SHALL grant at most one request per cycle. Grants are combinational in the request cycle.
REQ-023 Default priority SHALL be data over fetch.
REQ-024 Fetch SHALL win when both IReq and DReq are high and StarveCnt == STARVE_MAX.
REQ-025 StarveCnt (2-bit, saturating) SHALL update as follows:
- increment on each cycle with IReq & ~IGnt;
- clear on IGnt;
- clear on a cycle with IReq low.
REQ-026 On a grant, MemCen SHALL be 0. MemAddr, MemWrEn, MemWrMask and MemWrData SHALL mux from the winner; fetch forces MemWrEn=0 and MemWrMask=0.
REQ-027 With no grant, MemCen SHALL be 1 and MemWrEn SHALL be 0. Other SRAM outputs are don't-care but SHALL be held at their last value.
REQ-028 RdOwner FSM SHALL have states IDLE, IRD, DRD and DWR. The next state is set by the current-cycle grant:
- IGnt -> IRD;
- DGnt & ~DWrEn -> DRD;
- DGnt & DWrEn -> DWR;
- no grant -> IDLE.
REQ-029 In IRD, IRdValid SHALL be 1 and IRdData = MemRdData. In DRD, DRdValid SHALL be 1 and DRdData = MemRdData.
REQ-030 In IDLE and DWR, both valids SHALL be 0.
REQ-031 Read latency SHALL be exactly 1 cycle, with back-to-back grants at full throughput (one access per cycle).
REQ-032 Requesters hold Req and payload stable until Gnt. The arbiter SHALL NOT depend on this: a dropped request is simply not granted.
REQ-033 Stores SHALL produce no valid response. A store followed by a load to the same address SHALL return the new data (SRAM write-first not required, because the load issues in a later cycle).

Reset
REQ-034 While rst_n == 0 at a clock edge, the FSM SHALL enter IDLE and StarveCnt SHALL clear to 0.
REQ-035 While rst_n == 0, all grants SHALL be forced to 0, MemCen SHALL be 1 and MemWrEn SHALL be 0.
REQ-036 Reset asserted in the cycle after a read grant SHALL suppress that cycle's IRdValid/DRdValid; the in-flight read is discarded.
REQ-037 Outputs after reset SHALL be: IGnt, DGnt, IRdValid, DRdValid = 0; MemCen = 1; FeStall = IReq.

Structure
REQ-038 The RdOwner state enum SHALL be placed in ZionDataType as ArbOwnerType.
REQ-039 CpuType SHALL be used for all 32-bit data ports.
REQ-040 A single sub-module, arb_starve_cnt (saturating counter with clear), is natural. Everything else SHALL be flat.

Verification
REQ-041 Fetch only: IReq=1, IAddr=0x010, MemRdData=0x00000013 -> IGnt=1 and MemCen=0 in cycle 0; IRdValid=1 and IRdData=0x00000013 in cycle 1.
REQ-042 Simultaneous requests: IReq=1, DReq=1 load DAddr=0x100 -> DGnt=1, IGnt=0, FeStall=1; DRdValid=1 next cycle.
REQ-043 Starvation: DReq held high with IReq held high for 4 cycles -> cycles 0-2 DGnt; cycle 3 IGnt=1, StarveCnt back to 0.
REQ-044 Store: DReq=1, DWrEn=1, DAddr=0x020, DWrMask=0x0000FFFF, DWrData=0xABCD1234 -> MemWrEn=1 with the same mask and data; no DRdValid next cycle. A later load of 0x020 returns 0x????1234 per SRAM model.
REQ-045 Reset mid-read: load granted in cycle 0, rst_n=0 in cycle 1 -> DRdValid=0 in cycle 1; FSM is IDLE in cycle 2.
REQ-046 Back-to-back: alternating I and D loads for 8 cycles -> one valid per cycle, each routed to the correct owner, with no gaps.
